// File: rtl/serial_alu.sv
// Bit-serial ALU: AND/OR/XOR/ADD/SUB on WIDTH-bit operands, one bit per clock, LSB first.
// Operands and control are captured at start so the inputs may change while the operation runs.
`ifndef CONTROL_WIDTH
`define CONTROL_WIDTH 5
`endif

// state | meaning
// IDLE  | waiting for start_i; outputs hold the last completed result
// RUN   | processing bit cnt_q of the captured operands
// DONE  | results valid, done_o pulses for this single cycle
module serial_alu #(
    parameter int WIDTH = 8,
    parameter int F0    = 0,
    parameter int F1    = 1,
    parameter int F2    = 2,
    parameter int F3    = 3,
    parameter int F4    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [WIDTH-1:0]          a_i,
    input  logic [WIDTH-1:0]          b_i,
    input  logic [`CONTROL_WIDTH-1:0] f_i,
    input  logic                      carry_in_i,
    input  logic                      borrow_in_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [WIDTH-1:0]          result_o,
    output logic                      carry_out_o,
    output logic                      borrow_out_o,
    output logic                      zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          a_q, a_d, b_q, b_d, res_sh_q, res_sh_d;
    logic [`CONTROL_WIDTH-1:0] f_q, f_d;
    logic                      c_q, c_d, br_q, br_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]          result_q, result_d;
    logic                      carry_out_q, carry_out_d, borrow_out_q, borrow_out_d;
    logic                      zero_q, zero_d;

    logic [2:0]       sel;
    logic             ap, bp, bit_r, c_nx, br_nx;
    logic [WIDTH-1:0] res_nx;

    always_comb begin
        sel    = {f_q[F2], f_q[F1], f_q[F0]};
        ap     = a_q[cnt_q] ^ f_q[F4];
        bp     = b_q[cnt_q] & f_q[F3];
        c_nx   = (ap & bp) | (c_q & (ap ^ bp));
        br_nx  = (~ap & bp) | (br_q & ~(ap ^ bp));
        case (sel)
            3'b000:  bit_r = ap & bp;
            3'b001:  bit_r = ap | bp;
            3'b010:  bit_r = ap ^ bp;
            3'b011:  bit_r = ap ^ bp ^ c_q;
            3'b100:  bit_r = ap ^ bp ^ br_q;
            default: bit_r = 1'b0;
        endcase
        // each bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB
        res_nx = {bit_r, res_sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        f_d          = f_q;
        c_d          = c_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        res_sh_d     = res_sh_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        result_d     = result_q;
        carry_out_d  = carry_out_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    f_d     = f_i;
                    c_d     = carry_in_i;
                    br_d    = borrow_in_i;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                res_sh_d = res_nx;
                c_d      = c_nx;
                br_d     = br_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    cnt_d        = '0;
                    result_d     = res_nx;
                    carry_out_d  = (sel == 3'b011) & c_nx;
                    borrow_out_d = (sel == 3'b100) & br_nx;
                    zero_d       = ~|res_nx;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            c_q          <= 1'b0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            res_sh_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            carry_out_q  <= 1'b0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            f_q          <= f_d;
            c_q          <= c_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            res_sh_q     <= res_sh_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            carry_out_q  <= carry_out_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign carry_out_o  = carry_out_q;
    assign borrow_out_o = borrow_out_q;
    assign zero_o       = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8): directed vector table, random ops against
// an arithmetic reference model, and hand-written reset/busy/back-to-back sequences.
module tb_serial_alu;

    logic       clk = 1'b0;
    logic       rst_i, start_i, carry_in_i, borrow_in_i;
    logic [7:0] a_i, b_i;
    logic [4:0] f_i;
    logic       busy_o, done_o, carry_out_o, borrow_out_o, zero_o;
    logic [7:0] result_o;

    int checks   = 0;
    int failures = 0;

    serial_alu #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .a_i(a_i), .b_i(b_i), .f_i(f_i),
        .carry_in_i(carry_in_i), .borrow_in_i(borrow_in_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .carry_out_o(carry_out_o), .borrow_out_o(borrow_out_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b;
        logic [4:0] f;
        logic       cin, bin;
        logic [7:0] res;
        logic       c, br;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the conditioned operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [4:0] f,
                                  input logic cin, input logic bin,
                                  output logic [7:0] r, output logic c, output logic br);
        logic [7:0] ap, bp;
        logic [8:0] t;
        ap = a ^ {8{f[4]}};
        bp = f[3] ? b : 8'h00;
        r = 8'h00; c = 1'b0; br = 1'b0;
        case (f[2:0])
            3'd0: r = ap & bp;
            3'd1: r = ap | bp;
            3'd2: r = ap ^ bp;
            3'd3: begin t = {1'b0, ap} + {1'b0, bp} + {8'h00, cin}; r = t[7:0]; c = t[8]; end
            3'd4: begin t = {1'b0, ap} - {1'b0, bp} - {8'h00, bin}; r = t[7:0]; br = t[8]; end
            default: r = 8'h00;
        endcase
    endfunction

    // Starts one operation from IDLE (called just after a negedge) and checks the full transaction.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] f,
                          input logic cin, input logic bin,
                          input logic [7:0] er, input logic ec, input logic ebr, input string tag);
        int n;
        a_i = a; b_i = b; f_i = f; carry_in_i = cin; borrow_in_i = bin; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i = ~a; b_i = ~b; f_i = ~f; carry_in_i = ~cin; borrow_in_i = ~bin;
        n = 0;
        while (busy_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, n, 8);
        chk({tag, " done"}, done_o, 1);
        chk({tag, " result"}, result_o, er);
        chk({tag, " carry"}, carry_out_o, ec);
        chk({tag, " borrow"}, borrow_out_o, ebr);
        chk({tag, " zero"}, zero_o, (er == 8'h00));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done_o, 0);
        chk({tag, " result_hold"}, result_o, er);
    endtask

    initial begin
        vec_t       vecs[10];
        logic [7:0] ra, rb, er;
        logic [4:0] rf;
        logic       rc, rbi, ec, ebr;
        int         rises[$];
        int         n, dn;
        logic       prev_busy;

        vecs[0] = '{8'hF0, 8'h20, 5'b01011, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{8'h05, 8'h07, 5'b01100, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[2] = '{8'hAA, 8'hAA, 5'b01010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h0F, 8'hFF, 5'b10001, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'hCC, 8'hAA, 5'b01000, 1'b0, 1'b0, 8'h88, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 5'b01011, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h0F, 5'b01100, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 5'b01101, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'hFF, 5'b00011, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[9] = '{8'h00, 8'h01, 5'b11100, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};

        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; f_i = '0;
        carry_in_i = 1'b0; borrow_in_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset result", result_o, 0);
        chk("reset carry", carry_out_o, 0);
        chk("reset borrow", borrow_out_o, 0);
        chk("reset zero", zero_o, 1);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].cin, vecs[i].bin,
                   vecs[i].res, vecs[i].c, vecs[i].br, $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rf = {1'($urandom), 1'($urandom), 3'($urandom_range(0, 7))};
            rc = 1'($urandom); rbi = 1'($urandom);
            model(ra, rb, rf, rc, rbi, er, ec, ebr);
            run_op(ra, rb, rf, rc, rbi, er, ec, ebr, $sformatf("rnd%0d", i));
        end

        // second start during RUN must be ignored
        a_i = 8'h12; b_i = 8'h34; f_i = 5'b01011; carry_in_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        a_i = 8'hFF; b_i = 8'hFF; f_i = 5'b01100; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("guard done", done_o, 1);
        chk("guard result", result_o, 8'h46);
        chk("guard borrow", borrow_out_o, 0);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy_o) dn++;
        end
        chk("guard no_queue", dn, 0);

        // reset on the third RUN cycle aborts without a done pulse
        a_i = 8'hF0; b_i = 8'h20; f_i = 5'b01011; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort in_run", busy_o, 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort busy", busy_o, 0);
        chk("abort done", done_o, 0);
        chk("abort result", result_o, 0);
        chk("abort zero", zero_o, 1);
        chk("abort carry", carry_out_o, 0);
        dn = 0;
        repeat (12) begin
            if (done_o || busy_o) dn++;
            @(negedge clk);
        end
        chk("abort no_done", dn, 0);

        // reset during DONE clears the just-delivered result
        a_i = 8'hFF; b_i = 8'hFF; f_i = 5'b01000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("done_rst seen", done_o, 1);
        chk("done_rst result", result_o, 8'hFF);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("done_rst result_clr", result_o, 0);
        chk("done_rst zero", zero_o, 1);

        // reset wins over start in the same cycle
        rst_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; start_i = 1'b0;
        chk("rst_prio busy", busy_o, 0);
        @(negedge clk);
        chk("rst_prio idle", busy_o, 0);

        // start held high: acceptances every WIDTH+2 cycles
        a_i = 8'h01; b_i = 8'h01; f_i = 5'b01011; carry_in_i = 1'b0; start_i = 1'b1;
        prev_busy = busy_o;
        dn = 0;
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            if (busy_o && !prev_busy) rises.push_back(t);
            if (done_o) dn++;
            prev_busy = busy_o;
        end
        start_i = 1'b0;
        chk("b2b acceptances", rises.size(), 4);
        chk("b2b done_pulses", dn, 3);
        for (int k = 1; k < rises.size(); k++)
            chk($sformatf("b2b period%0d", k), rises[k] - rises[k-1], 10);
        repeat (12) @(negedge clk);
        chk("b2b result", result_o, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
